rom_page_ctrl: RTL and testbench
================================

Name: rom_page_ctrl

Overview:
- Parametrised controller for the i4001 ROM programmer/viewer board.
- Owns mode selection (INPUT / RUN / DEBUG), the ROM write pointer, the page counter and the column-scan sequencer that feeds the dot-matrix driver.
- Sits between the switch bank and both the ROM array and the Matrix driver; the page number goes to the 7-segment driver.
- Generalises the hard-wired 2048x16, 32-column, 64-page layout and adds single-clock operation, debounced stepping, correct page tracking and paced scanning.

Parameters:
- ADDR_W, 11, ROM address width
- DATA_W, 16, ROM word / matrix column width
- COL_LOG2, 5, log2 of columns per page (page = 2^COL_LOG2 words); pages = 2^(ADDR_W-COL_LOG2)
- SCAN_DIV, 1024, CLK cycles per scanned column in RUN/DEBUG (>=2)

Ports:
- CLK  in  1  system clock, sole clock
- RESET  in  1  asynchronous, active-high reset
- SWITCH  in  1  0 = INPUT mode, 1 = RUN/DEBUG
- RUN_SEL  in  1  with SWITCH=1: 0 = RUN, 1 = DEBUG
- STEP  in  1  raw push-button (asynchronous, bouncing)
- PAGE_DIR  in  1  DEBUG page step direction: 1 up, 0 down
- CHIP_SEL  in  1  DEBUG page step enabled only when 0 (i4001 selected)
- DATA_IN  in  DATA_W  word to program
- ROM_RDATA  in  DATA_W  ROM read data, valid 1 cycle after ROM_ADDR
- ROM_ADDR  out  ADDR_W  ROM address
- ROM_WE  out  1  one-cycle write strobe
- ROM_WDATA  out  DATA_W  write data
- DMD_DATA  out  DATA_W  column data to matrix
- DMD_COL  out  COL_LOG2  column index to matrix
- DMD_LOAD  out  1  one-cycle column load strobe
- PAGE  out  ADDR_W-COL_LOG2  page shown on 7-seg
- MODE  out  2  0 INPUT, 1 RUN, 2 DEBUG
- ERR  out  1  sticky verify mismatch (only with WRITE_VERIFY_EN, else tied 0)

Behaviour:
- Reset values: all outputs 0, write pointer 0, debug page 0, scan column 0, FSM IDLE.
- SWITCH, RUN_SEL and STEP each pass through a 2-flop synchroniser.
- STEP is debounced: the level must be stable for 2^12 cycles before it is accepted. A step event is a one-cycle pulse on an accepted 0->1 transition.
- MODE is registered from the synchronised inputs. When MODE changes, the FSM returns to IDLE at the next cycle and the scan column resets to 0. The write pointer and debug page are retained.
- FSM states: IDLE, WRITE, VERIFY_ADDR, VERIFY_CHK, SCAN_ADDR, SCAN_LOAD.
- INPUT mode, on a step event: IDLE->WRITE.
  - WRITE drives ROM_ADDR=wptr, ROM_WDATA=DATA_IN, ROM_WE=1, DMD_COL=wptr[COL_LOG2-1:0], DMD_DATA=DATA_IN, DMD_LOAD=1.
  - Next cycle: wptr+1 (wraps from 2^ADDR_W-1 to 0), return to IDLE.
- PAGE in INPUT mode = wptr[ADDR_W-1:COL_LOG2], always combinationally consistent with the pointer. There is no off-by-one: the page increments exactly when the pointer crosses a page boundary.
- RUN/DEBUG modes: free-running divider. Every SCAN_DIV cycles, IDLE->SCAN_ADDR.
  - SCAN_ADDR drives ROM_ADDR={page,col}.
  - SCAN_LOAD (next cycle) drives DMD_DATA=ROM_RDATA, DMD_COL=col, DMD_LOAD=1, then col+1 mod 2^COL_LOG2 and return to IDLE.
  - Address-to-load latency: exactly 1 cycle.
- RUN shows page = wptr page frozen at mode entry.
- DEBUG: a step event with CHIP_SEL=0 changes the debug page by ±1 per PAGE_DIR, with wrap 0<->max.
  - The page change takes effect at the next SCAN_ADDR and the scan column resets to 0.
  - A step event with CHIP_SEL=1 is ignored.
- A step event during any non-IDLE state is held pending for one event and serviced on return to IDLE. Further events are dropped.
- Asynchronous RESET mid-WRITE deasserts ROM_WE immediately. The pointer returns to 0.

Optional Feature:
- Macro: WRITE_VERIFY_EN.
- Defined: WRITE is followed by VERIFY_ADDR (read the same address) and VERIFY_CHK.
  - VERIFY_CHK compares ROM_RDATA with the latched write data.
  - Mismatch sets ERR; ERR is sticky until RESET or SWITCH 1->0.
  - The pointer increments after VERIFY_CHK; write cost is 3 cycles.
- Undefined: WRITE returns directly to IDLE, VERIFY states are absent, ERR is constant 0.

Decomposition:
- Package rom_page_pkg: MODE_INPUT/MODE_RUN/MODE_DEBUG encodings, FSM state enum, debounce width constant.
- Sub-module step_debounce: synchroniser + stability counter + rising-edge pulse. Instantiated for STEP only.

Test Plan:
- Reset with all inputs 0 -> MODE=0, PAGE=0, ROM_WE=0, DMD_LOAD=0, ROM_ADDR=0.
- INPUT mode, 33 clean STEPs with DATA_IN=16'hA5A5 -> 33 ROM_WE pulses at addrs 0..32; PAGE=1 after the 32nd; DMD_COL of the 33rd = 0.
- INPUT mode, pointer preset to 2047, one STEP -> write at 2047, pointer 0, PAGE 63->0.
- DEBUG mode, PAGE_DIR=0, CHIP_SEL=0, STEP from page 0 -> PAGE=63; next SCAN_ADDR at ROM_ADDR=2016, DMD_COL=0.
- RUN mode, SCAN_DIV=4, ROM model returns addr as data -> DMD_LOAD every 4 cycles; DMD_DATA equals the previous-cycle ROM_ADDR; column wraps 31->0.
- STEP bouncing (toggles every 100 cycles for 2000 cycles, then stable high) -> exactly one write; RESET asserted during WRITE -> ROM_WE falls in the same cycle; with WRITE_VERIFY_EN and a corrupting ROM model -> ERR=1.

Source files
------------

// File: rtl/rom_page_pkg.sv
// rom_page_pkg: mode encodings, FSM state codes and debounce width shared by rom_page_ctrl
package rom_page_pkg;
    localparam logic [1:0] MODE_INPUT = 2'd0;
    localparam logic [1:0] MODE_RUN   = 2'd1;
    localparam logic [1:0] MODE_DEBUG = 2'd2;
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_WRITE       = 3'd1;
    localparam logic [2:0] ST_VERIFY_ADDR = 3'd2;
    localparam logic [2:0] ST_VERIFY_CHK  = 3'd3;
    localparam logic [2:0] ST_SCAN_ADDR   = 3'd4;
    localparam logic [2:0] ST_SCAN_LOAD   = 3'd5;
    localparam int DEB_W = 12;
endpackage

// File: rtl/step_debounce.sv
// step_debounce: 2-flop synchroniser, stability filter and rising-edge pulse for a bouncing push-button
//   clk   : clock
//   rst   : asynchronous active-high reset
//   din   : raw asynchronous button level
//   pulse : one-cycle pulse per accepted 0->1 transition (level stable for 2^CNT_W cycles)
module step_debounce
    import rom_page_pkg::*;
#(
    parameter int CNT_W = DEB_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d, pulse_q, pulse_d, diff;
    always_comb begin
        sync_d   = {sync_q[0], din};
        diff     = sync_q[1] != stable_q;
        // counts only while the input disagrees with the accepted level; any agreement restarts it
        cnt_d    = diff ? cnt_q + 1'b1 : '0;
        stable_d = (diff && (&cnt_q)) ? sync_q[1] : stable_q;
        pulse_d  = stable_d & ~stable_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
        end
    end
    assign pulse = pulse_q;
endmodule

// File: rtl/rom_page_ctrl.sv
// rom_page_ctrl: mode select, ROM write pointer, page tracking and paced column scan for the i4001 ROM board
//   Optional macro WRITE_VERIFY_EN: read back every written word and raise sticky ERR on mismatch
//   CLK, RESET           : sole clock, asynchronous active-high reset
//   SWITCH, RUN_SEL      : mode select (0 = INPUT; 1 with RUN_SEL 0/1 = RUN/DEBUG)
//   STEP                 : raw push-button; PAGE_DIR / CHIP_SEL steer DEBUG page stepping
//   DATA_IN              : word to program; ROM_RDATA: ROM data one cycle after ROM_ADDR
//   ROM_ADDR/WE/WDATA    : ROM port; DMD_DATA/COL/LOAD: matrix column load
//   PAGE, MODE, ERR      : page for 7-seg, current mode, sticky verify error
module rom_page_ctrl
    import rom_page_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int COL_LOG2  = 5,
    parameter int SCAN_DIV  = 1024,
    parameter int DEB_CNT_W = DEB_W
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         SWITCH,
    input  logic                         RUN_SEL,
    input  logic                         STEP,
    input  logic                         PAGE_DIR,
    input  logic                         CHIP_SEL,
    input  logic [DATA_W-1:0]            DATA_IN,
    input  logic [DATA_W-1:0]            ROM_RDATA,
    output logic [ADDR_W-1:0]            ROM_ADDR,
    output logic                         ROM_WE,
    output logic [DATA_W-1:0]            ROM_WDATA,
    output logic [DATA_W-1:0]            DMD_DATA,
    output logic [COL_LOG2-1:0]          DMD_COL,
    output logic                         DMD_LOAD,
    output logic [ADDR_W-COL_LOG2-1:0]   PAGE,
    output logic [1:0]                   MODE,
    output logic                         ERR
);
    localparam int PG_W  = ADDR_W - COL_LOG2;
    localparam int DIV_W = $clog2(SCAN_DIV);
    logic [1:0]          sw_q, sw_d, rs_q, rs_d, mode_q, mode_d;
    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [PG_W-1:0]     dbg_q, dbg_d, page;
    logic [COL_LOG2-1:0] col_q, col_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                pend_q, pend_d, step, svc, tick, chg, we, load;
    step_debounce #(.CNT_W(DEB_CNT_W)) u_step (.clk(CLK), .rst(RESET), .din(STEP), .pulse(step));
    always_comb begin
        sw_d    = {sw_q[0], SWITCH};
        rs_d    = {rs_q[0], RUN_SEL};
        mode_d  = !sw_q[1] ? MODE_INPUT : rs_q[1] ? MODE_DEBUG : MODE_RUN;
        chg     = mode_d != mode_q;
        tick    = div_q == DIV_W'(SCAN_DIV - 1);
        svc     = step | pend_q;
        // RUN reuses the write-pointer page: the pointer cannot move outside INPUT, so it stays frozen
        page    = (mode_q == MODE_DEBUG) ? dbg_q : wptr_q[ADDR_W-1:COL_LOG2];
        state_d = state_q;
        wptr_d  = wptr_q;
        dbg_d   = dbg_q;
        col_d   = col_q;
        div_d   = (mode_q == MODE_INPUT || tick) ? '0 : div_q + 1'b1;
        pend_d  = pend_q | step;
        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (mode_q == MODE_INPUT && svc) state_d = ST_WRITE;
                if (mode_q == MODE_DEBUG && svc && !CHIP_SEL) begin
                    dbg_d = PAGE_DIR ? dbg_q + 1'b1 : dbg_q - 1'b1;
                    col_d = '0;
                end
                if (mode_q != MODE_INPUT && tick) state_d = ST_SCAN_ADDR;
            end
`ifdef WRITE_VERIFY_EN
            ST_WRITE:       state_d = ST_VERIFY_ADDR;
            ST_VERIFY_ADDR: state_d = ST_VERIFY_CHK;
            ST_VERIFY_CHK: begin
                state_d = ST_IDLE;
                wptr_d  = wptr_q + 1'b1;
            end
`else
            ST_WRITE: begin
                state_d = ST_IDLE;
                wptr_d  = wptr_q + 1'b1;
            end
`endif
            ST_SCAN_ADDR: state_d = ST_SCAN_LOAD;
            ST_SCAN_LOAD: begin
                col_d   = col_q + 1'b1;
                // a tick landing here (SCAN_DIV = 2) chains straight into the next column
                state_d = tick ? ST_SCAN_ADDR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (chg) begin
            state_d = ST_IDLE;
            col_d   = '0;
            pend_d  = 1'b0;
            div_d   = '0;
        end
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sw_q    <= '0;
            rs_q    <= '0;
            mode_q  <= MODE_INPUT;
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            dbg_q   <= '0;
            col_q   <= '0;
            div_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            sw_q    <= sw_d;
            rs_q    <= rs_d;
            mode_q  <= mode_d;
            state_q <= state_d;
            wptr_q  <= wptr_d;
            dbg_q   <= dbg_d;
            col_q   <= col_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
        end
    end
    always_comb begin
        we        = state_q == ST_WRITE;
        load      = state_q == ST_SCAN_LOAD;
        ROM_ADDR  = (mode_q == MODE_INPUT) ? wptr_q : {page, col_q};
        ROM_WE    = we;
        ROM_WDATA = we ? DATA_IN : '0;
        DMD_LOAD  = we | load;
        DMD_DATA  = we ? DATA_IN : load ? ROM_RDATA : '0;
        DMD_COL   = we ? wptr_q[COL_LOG2-1:0] : load ? col_q : '0;
        PAGE      = page;
        MODE      = mode_q;
    end
`ifdef WRITE_VERIFY_EN
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              err_q, err_d;
    always_comb begin
        wdat_d = we ? DATA_IN : wdat_q;
        // leaving RUN/DEBUG for INPUT is the synchronised SWITCH 1->0, which clears the error
        err_d  = (chg && mode_d == MODE_INPUT) ? 1'b0
               : err_q | (state_q == ST_VERIFY_CHK && ROM_RDATA != wdat_q);
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wdat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdat_q <= wdat_d;
            err_q  <= err_d;
        end
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif
endmodule

// File: tb/tb_rom_page_ctrl.sv
// tb_rom_page_ctrl: directed self-checking bench for rom_page_ctrl with a small ROM model
module tb_rom_page_ctrl;
`ifdef WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    logic        CLK = 1'b0, RESET = 1'b1, SWITCH = 1'b0, RUN_SEL = 1'b0, STEP = 1'b0;
    logic        PAGE_DIR = 1'b0, CHIP_SEL = 1'b0;
    logic [15:0] DATA_IN = 16'h0000, ROM_RDATA = 16'h0000;
    logic [10:0] ROM_ADDR;
    logic        ROM_WE, DMD_LOAD, ERR;
    logic [15:0] ROM_WDATA, DMD_DATA;
    logic [4:0]  DMD_COL;
    logic [5:0]  PAGE;
    logic [1:0]  MODE;
    logic        echo = 1'b0, corrupt = 1'b0;
    logic [15:0] mem [0:2047];
    int          checks = 0, errors = 0, we_cnt = 0;
    rom_page_ctrl #(.SCAN_DIV(4), .DEB_CNT_W(7)) dut (
        .CLK(CLK), .RESET(RESET), .SWITCH(SWITCH), .RUN_SEL(RUN_SEL), .STEP(STEP),
        .PAGE_DIR(PAGE_DIR), .CHIP_SEL(CHIP_SEL), .DATA_IN(DATA_IN), .ROM_RDATA(ROM_RDATA),
        .ROM_ADDR(ROM_ADDR), .ROM_WE(ROM_WE), .ROM_WDATA(ROM_WDATA), .DMD_DATA(DMD_DATA),
        .DMD_COL(DMD_COL), .DMD_LOAD(DMD_LOAD), .PAGE(PAGE), .MODE(MODE), .ERR(ERR)
    );
    always #5 CLK = ~CLK;
    always @(posedge CLK) begin
        if (ROM_WE) mem[ROM_ADDR] <= ROM_WDATA;
        ROM_RDATA <= echo ? {5'b0, ROM_ADDR} : mem[ROM_ADDR] ^ {15'b0, corrupt};
    end
    always @(negedge CLK) if (ROM_WE) we_cnt <= we_cnt + 1;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic do_step(input int exp_addr);
        bit seen;
        seen = 1'b0;
        STEP = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (ROM_WE && !seen) begin
                seen = 1'b1;
                chk("we_addr", ROM_ADDR, exp_addr);
                chk("we_col", DMD_COL, exp_addr % 32);
                chk("we_wdata", ROM_WDATA, DATA_IN);
                chk("we_dmd_data", DMD_DATA, DATA_IN);
                chk("we_dmd_load", DMD_LOAD, 1);
            end
        end
        chk("we_seen", seen, 1);
        STEP = 1'b0;
        repeat (200) @(negedge CLK);
    endtask
    task automatic pulse_step();
        STEP = 1'b1;
        repeat (200) @(negedge CLK);
        STEP = 1'b0;
        repeat (200) @(negedge CLK);
    endtask
    initial begin
        bit          seen;
        int          n0, gap, k;
        logic [10:0] prev;
        repeat (3) @(negedge CLK);
        chk("rst_mode", MODE, 0);
        chk("rst_page", PAGE, 0);
        chk("rst_we", ROM_WE, 0);
        chk("rst_load", DMD_LOAD, 0);
        chk("rst_addr", ROM_ADDR, 0);
        chk("rst_err", ERR, 0);
        RESET = 1'b0;
        DATA_IN = 16'hA5A5;
        repeat (5) @(negedge CLK);
        for (int i = 0; i < 33; i++) begin
            do_step(i);
            chk("input_page", PAGE, (i + 1) / 32);
        end
        chk("input_we_count", we_cnt, 33);
        chk("input_err_clean", ERR, 0);
        force dut.wptr_q = 11'd2047;
        @(negedge CLK);
        release dut.wptr_q;
        @(negedge CLK);
        chk("wrap_page_pre", PAGE, 63);
        DATA_IN = 16'h3C5A;
        do_step(2047);
        chk("wrap_page_post", PAGE, 0);
        chk("wrap_addr_post", ROM_ADDR, 0);
        n0 = we_cnt;
        for (int i = 0; i < 20; i++) begin
            STEP = ~STEP;
            repeat (100) @(negedge CLK);
        end
        chk("bounce_no_write", we_cnt - n0, 0);
        do_step(0);
        chk("bounce_one_write", we_cnt - n0, 1);
        corrupt = 1'b1;
        do_step(1);
        corrupt = 1'b0;
        chk("verify_err", ERR, VERIFY);
        n0 = we_cnt;
        echo = 1'b1;
        SWITCH = 1'b1;
        RUN_SEL = 1'b1;
        for (int i = 0; i < 10 && MODE !== 2'd2; i++) @(negedge CLK);
        chk("dbg_mode", MODE, 2);
        chk("dbg_page_start", PAGE, 0);
        STEP = 1'b1;
        for (int i = 0; i < 300 && PAGE !== 6'd63; i++) @(negedge CLK);
        chk("dbg_page_down", PAGE, 63);
        prev = ROM_ADDR;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (DMD_LOAD) begin
                seen = 1'b1;
                chk("dbg_scan_addr", prev, 2016);
                chk("dbg_scan_col", DMD_COL, 0);
                chk("dbg_scan_data", DMD_DATA, 2016);
            end
            prev = ROM_ADDR;
        end
        chk("dbg_load_seen", seen, 1);
        repeat (200) @(negedge CLK);
        STEP = 1'b0;
        repeat (200) @(negedge CLK);
        CHIP_SEL = 1'b1;
        pulse_step();
        chk("dbg_chipsel_ignored", PAGE, 63);
        CHIP_SEL = 1'b0;
        PAGE_DIR = 1'b1;
        pulse_step();
        chk("dbg_page_up_wrap", PAGE, 0);
        chk("dbg_no_writes", we_cnt - n0, 0);
        RUN_SEL = 1'b0;
        for (int i = 0; i < 10 && MODE !== 2'd1; i++) @(negedge CLK);
        chk("run_mode", MODE, 1);
        chk("run_page", PAGE, 0);
        gap = 0;
        k = 0;
        prev = ROM_ADDR;
        for (int i = 0; i < 200 && k < 34; i++) begin
            @(negedge CLK);
            gap++;
            if (DMD_LOAD) begin
                chk("run_col", DMD_COL, k % 32);
                chk("run_data_prev_addr", DMD_DATA, prev);
                chk("run_data", DMD_DATA, k % 32);
                if (k > 0) chk("run_gap", gap, 4);
                gap = 0;
                k++;
            end
            prev = ROM_ADDR;
        end
        chk("run_loads", k, 34);
        echo = 1'b0;
        SWITCH = 1'b0;
        for (int i = 0; i < 10 && MODE !== 2'd0; i++) @(negedge CLK);
        chk("back_mode", MODE, 0);
        chk("back_err_cleared", ERR, 0);
        chk("back_addr", ROM_ADDR, 2);
        STEP = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLK);
            seen = ROM_WE;
        end
        chk("rst_we_seen", seen, 1);
        chk("rst_we_addr", ROM_ADDR, 2);
        RESET = 1'b1;
        STEP = 1'b0;
        #1;
        chk("rst_we_drop", ROM_WE, 0);
        chk("rst_load_drop", DMD_LOAD, 0);
        chk("rst_ptr_zero", ROM_ADDR, 0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        chk("post_rst_page", PAGE, 0);
        chk("post_rst_mode", MODE, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
